sap_control_sequencer: RTL

Parametrised SAP-1 control unit: a one-hot ring counter (T-states) combined with a configurable opcode decoder that emits the full 12-bit control word each cycle. It sits between the instruction register (opcode field) and every bus-driving and register-loading unit of the SAP-1 datapath. It extends plain opcode decoding with:
- run/single-step control
- a latched halt
- a sticky illegal-opcode flag
- an instruction-retired counter

---
 rtl/sap_control_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-1 control unit: one-hot T-state ring plus opcode decoder driving the
// 12-bit control word, with run/step, latched halt, illegal flag, retire count.
module sap_control_sequencer #(
   parameter int OP_W = 4,
   parameter int T_STATES = 6,
   parameter int CNT_W = 8,
   parameter logic [OP_W-1:0] OP_LDA = OP_W'(0),
   parameter logic [OP_W-1:0] OP_ADD = OP_W'(1),
   parameter logic [OP_W-1:0] OP_SUB = OP_W'(2),
   parameter logic [OP_W-1:0] OP_OUT = OP_W'(14),
   parameter logic [OP_W-1:0] OP_HLT = OP_W'(15)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   input  logic [OP_W-1:0]     op_code,
   output logic [T_STATES-1:0] t_state,
   output logic [11:0]         ctrl,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_cnt
);

   localparam logic [11:0] C_CP = 12'h800;
   localparam logic [11:0] C_EP = 12'h400;
   localparam logic [11:0] C_LM = 12'h200;
   localparam logic [11:0] C_CE = 12'h100;
   localparam logic [11:0] C_LI = 12'h080;
   localparam logic [11:0] C_EI = 12'h040;
   localparam logic [11:0] C_LA = 12'h020;
   localparam logic [11:0] C_EA = 12'h010;
   localparam logic [11:0] C_SU = 12'h008;
   localparam logic [11:0] C_EU = 12'h004;
   localparam logic [11:0] C_LB = 12'h002;
   localparam logic [11:0] C_LO = 12'h001;

   logic [T_STATES-1:0] r_t_state;
   logic                r_halted;
   logic                r_illegal;
   logic [CNT_W-1:0]    r_cnt;

   logic        w_adv;
   logic        w_t4;
   logic        w_tlast;
   logic        w_is_lda;
   logic        w_is_add;
   logic        w_is_sub;
   logic        w_is_out;
   logic        w_is_hlt;
   logic        w_op_known;
   logic [11:0] w_ctrl;

   assign w_is_lda   = (op_code == OP_LDA);
   assign w_is_add   = (op_code == OP_ADD);
   assign w_is_sub   = (op_code == OP_SUB);
   assign w_is_out   = (op_code == OP_OUT);
   assign w_is_hlt   = (op_code == OP_HLT);
   assign w_op_known = w_is_lda | w_is_add | w_is_sub | w_is_out | w_is_hlt;

   assign w_adv   = ~r_halted & (run | step);
   assign w_t4    = r_t_state[3];
   assign w_tlast = r_t_state[T_STATES-1];

   // HLT at T4 latches regardless of run/step and freezes the ring in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_t_state <= T_STATES'(1);
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else if (!r_halted) begin
         if (w_t4 && w_is_hlt) begin
            r_halted <= 1'b1;
         end else if (w_adv) begin
            r_t_state <= {r_t_state[T_STATES-2:0], r_t_state[T_STATES-1]};
            if (w_t4 && !w_op_known) r_illegal <= 1'b1;
            if (w_tlast) r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_ctrl = '0;
      if (!r_halted) begin
         unique case (1'b1)
            r_t_state[0]: w_ctrl = C_EP | C_LM;
            r_t_state[1]: w_ctrl = C_CP;
            r_t_state[2]: w_ctrl = C_CE | C_LI;
            r_t_state[3]: begin
               if (w_is_lda | w_is_add | w_is_sub)
                  w_ctrl = C_EI | C_LM;
               else if (w_is_out)
                  w_ctrl = C_EA | C_LO;
            end
            r_t_state[4]: begin
               if (w_is_lda)
                  w_ctrl = C_CE | C_LA;
               else if (w_is_add | w_is_sub)
                  w_ctrl = C_CE | C_LB;
            end
            r_t_state[5]: begin
               if (w_is_add)
                  w_ctrl = C_EU | C_LA;
               else if (w_is_sub)
                  w_ctrl = C_SU | C_EU | C_LA;
            end
            default: w_ctrl = '0;
         endcase
      end
   end

   assign t_state   = r_t_state;
   assign ctrl      = w_ctrl;
   assign halted    = r_halted;
   assign illegal   = r_illegal;
   assign instr_cnt = r_cnt;

endmodule
